// File: rtl/led_zone_shifter.sv
// Frame serializer: fetches zone brightness values from the zone buffer and shifts
// them MSB-first onto the MiniLED driver chain, then pulses LE to latch the chain.
module led_zone_shifter #(
  parameter int unsigned ZONES     = 72,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned WORD_BITS = 16
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_start,
  input  logic [7:0] I_gray_data,
  output logic       O_rd_en,
  output logic [8:0] O_rd_addr,
  output logic       O_DCLK,
  output logic       O_SDI,
  output logic       O_LE,
  output logic       O_busy,
  output logic       O_done
);

  localparam int unsigned ZW = (ZONES > 1) ? $clog2(ZONES) : 1;
  localparam int unsigned BW = $clog2(WORD_BITS);
  localparam int unsigned PW = $clog2(CLK_DIV);

  localparam logic [ZW-1:0] ZoneLast  = ZW'(ZONES - 1);
  localparam logic [BW-1:0] BitLast   = BW'(WORD_BITS - 1);
  localparam logic [PW-1:0] PhaseLast = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PhaseHigh = PW'(CLK_DIV / 2);

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StShift, StLatch} state_e;

  state_e                 state_q, state_d;
  logic [ZW-1:0]          zone_q, zone_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [PW-1:0]          phase_q, phase_d;
  logic [WORD_BITS-1:0]   shreg_q, shreg_d;

  logic       rd_en_d, dclk_d, sdi_d, le_d, busy_d, done_d;
  logic [8:0] rd_addr_d;

  always_comb begin
    state_d = state_q;
    zone_d  = zone_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (I_start) begin
          state_d = StFetch;
          zone_d  = ZoneLast;
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        // Read data is valid here, one cycle after the FETCH read strobe.
        shreg_d = WORD_BITS'(I_gray_data) << (WORD_BITS - 8);
        bit_d   = BitLast;
        phase_d = '0;
        state_d = StShift;
      end
      StShift: begin
        if (phase_q == PhaseLast) begin
          phase_d = '0;
          shreg_d = shreg_q << 1;
          bit_d   = bit_q - BW'(1);
          if (bit_q == '0) begin
            if (zone_q == '0) begin
              state_d = StLatch;
            end else begin
              zone_d  = zone_q - ZW'(1);
              state_d = StFetch;
            end
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      StLatch: begin
        if (phase_q == PhaseLast) begin
          phase_d = '0;
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from next-state values so the registered pins line up with the state.
  always_comb begin
    rd_en_d   = (state_d == StFetch);
    rd_addr_d = (state_d == StFetch) ? 9'(zone_d) : O_rd_addr;
    dclk_d    = (state_d == StShift) && (phase_d >= PhaseHigh);
    sdi_d     = (state_d == StShift) && shreg_d[WORD_BITS-1];
    le_d      = (state_d == StLatch);
    busy_d    = (state_d != StIdle);
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q   <= StIdle;
      zone_q    <= ZoneLast;
      bit_q     <= '0;
      phase_q   <= '0;
      shreg_q   <= '0;
      O_rd_en   <= 1'b0;
      O_rd_addr <= '0;
      O_DCLK    <= 1'b0;
      O_SDI     <= 1'b0;
      O_LE      <= 1'b0;
      O_busy    <= 1'b0;
      O_done    <= 1'b0;
    end else begin
      state_q   <= state_d;
      zone_q    <= zone_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      shreg_q   <= shreg_d;
      O_rd_en   <= rd_en_d;
      O_rd_addr <= rd_addr_d;
      O_DCLK    <= dclk_d;
      O_SDI     <= sdi_d;
      O_LE      <= le_d;
      O_busy    <= busy_d;
      O_done    <= done_d;
    end
  end

endmodule

// File: tb/tb_led_zone_shifter.sv
// Directed bench: default-size shifter plus a small (ZONES=3, CLK_DIV=2, WORD_BITS=8) instance.
module tb_led_zone_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start_a, start_b, mode_a5, clr;
  logic [7:0] gray_a = 8'h00;
  logic [7:0] gray_b = 8'h00;

  logic       a_rd_en, a_dclk, a_sdi, a_le, a_busy, a_done;
  logic [8:0] a_rd_addr;
  logic       b_rd_en, b_dclk, b_sdi, b_le, b_busy, b_done;
  logic [8:0] b_rd_addr;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  led_zone_shifter u_dut_a (
    .I_clk(clk), .I_rst_n(rst_n), .I_start(start_a), .I_gray_data(gray_a),
    .O_rd_en(a_rd_en), .O_rd_addr(a_rd_addr), .O_DCLK(a_dclk), .O_SDI(a_sdi),
    .O_LE(a_le), .O_busy(a_busy), .O_done(a_done)
  );

  led_zone_shifter #(.ZONES(3), .CLK_DIV(2), .WORD_BITS(8)) u_dut_b (
    .I_clk(clk), .I_rst_n(rst_n), .I_start(start_b), .I_gray_data(gray_b),
    .O_rd_en(b_rd_en), .O_rd_addr(b_rd_addr), .O_DCLK(b_dclk), .O_SDI(b_sdi),
    .O_LE(b_le), .O_busy(b_busy), .O_done(b_done)
  );

  // Zone buffer models: one-cycle read latency.
  always @(posedge clk) begin
    if (a_rd_en) gray_a <= mode_a5 ? 8'hA5 : a_rd_addr[7:0];
    if (b_rd_en) gray_b <= b_rd_addr[7:0];
  end

  int a_busy_n, a_busy_first, a_busy_last, a_le_n, a_le_first, a_done_n, a_done_cyc;
  int a_rd_first, a_edges, a_first_rise, a_dclk_bad, a_nbit;
  logic [15:0] a_word;
  logic        a_dclk_prev, a_rd_prev;
  logic [8:0]  a_addrs[$];
  logic [15:0] a_words[$];

  always @(negedge clk) begin
    if (clr) begin
      a_busy_n = 0; a_busy_first = -1; a_busy_last = -1; a_le_n = 0; a_le_first = -1;
      a_done_n = 0; a_done_cyc = -1; a_rd_first = -1; a_edges = 0; a_first_rise = -1;
      a_dclk_bad = 0; a_nbit = 0; a_word = '0; a_dclk_prev = 1'b0; a_rd_prev = 1'b0;
      a_addrs.delete(); a_words.delete();
    end else begin
      if (a_busy) begin
        a_busy_n++;
        if (a_busy_first < 0) a_busy_first = cyc;
        a_busy_last = cyc;
      end
      if (a_le) begin
        a_le_n++;
        if (a_le_first < 0) a_le_first = cyc;
      end
      if (a_done) begin a_done_n++; a_done_cyc = cyc; end
      if (a_rd_en) begin
        a_addrs.push_back(a_rd_addr);
        if (a_rd_first < 0) a_rd_first = cyc;
      end
      if ((a_rd_en || a_rd_prev) && a_dclk) a_dclk_bad++;
      if (a_dclk && !a_dclk_prev) begin
        a_edges++;
        if (a_first_rise < 0) a_first_rise = cyc;
        a_word = {a_word[14:0], a_sdi};
        a_nbit++;
        if (a_nbit == 16) begin a_words.push_back(a_word); a_nbit = 0; end
      end
      a_dclk_prev = a_dclk;
      a_rd_prev   = a_rd_en;
    end
  end

  int b_busy_n, b_done_n, b_done_cyc, b_dclk_hi, b_edges, b_nbit;
  logic [7:0] b_word;
  logic       b_dclk_prev;
  int         b_rd_cycles[$];
  logic [7:0] b_words[$];

  always @(negedge clk) begin
    if (clr) begin
      b_busy_n = 0; b_done_n = 0; b_done_cyc = -1; b_dclk_hi = 0; b_edges = 0; b_nbit = 0;
      b_word = '0; b_dclk_prev = 1'b0; b_rd_cycles.delete(); b_words.delete();
    end else begin
      if (b_busy) b_busy_n++;
      if (b_done) begin b_done_n++; b_done_cyc = cyc; end
      if (b_rd_en) b_rd_cycles.push_back(cyc);
      if (b_dclk) b_dclk_hi++;
      if (b_dclk && !b_dclk_prev) begin
        b_edges++;
        b_word = {b_word[6:0], b_sdi};
        b_nbit++;
        if (b_nbit == 8) begin b_words.push_back(b_word); b_nbit = 0; end
      end
      b_dclk_prev = b_dclk;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Advance to just after the next falling edge so monitor updates are visible.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic run_a_frame(output int t0);
    clr = 1'b1; step(1); clr = 1'b0;
    t0 = cyc; start_a = 1'b1; step(1); start_a = 1'b0;
    for (int i = 0; i < 5000 && a_done_n < 1; i++) step(1);
    step(3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int t0, t1, bad;

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; mode_a5 = 1'b0; clr = 1'b1;
    step(3);
    chk("reset_outs_a", int'({a_rd_en, a_rd_addr, a_dclk, a_sdi, a_le, a_busy, a_done}), 0);
    rst_n = 1'b1; clr = 1'b0;
    step(4);
    chk("idle_busy_a", int'(a_busy), 0);
    chk("idle_outs_b", int'({b_rd_en, b_rd_addr, b_dclk, b_sdi, b_le, b_busy, b_done}), 0);

    // Small instance, I_start held high across the done cycle -> back-to-back frames.
    t0 = cyc; start_b = 1'b1;
    for (int i = 0; i < 200 && b_done_n < 1; i++) step(1);
    chk("b_done_cyc", b_done_cyc, t0 + 57);
    chk("b_busy_len", b_busy_n, 56);
    step(1);
    start_b = 1'b0;
    for (int i = 0; i < 200 && b_done_n < 2; i++) step(1);
    chk("b_done2_cyc", b_done_cyc, t0 + 114);
    chk("b_busy_total", b_busy_n, 112);
    chk("b_rd_count", b_rd_cycles.size(), 6);
    if (b_rd_cycles.size() == 6) begin
      chk("b_rd0_cyc", b_rd_cycles[0], t0 + 1);
      chk("b_rd1_cyc", b_rd_cycles[1], t0 + 19);
      chk("b_rd2_cyc", b_rd_cycles[2], t0 + 37);
      chk("b_rd3_cyc", b_rd_cycles[3], t0 + 58);
    end
    chk("b_dclk_hi", b_dclk_hi, 48);
    chk("b_edges", b_edges, 48);
    chk("b_words", b_words.size(), 6);
    if (b_words.size() == 6) begin
      chk("b_word0", int'(b_words[0]), 2);
      chk("b_word2", int'(b_words[2]), 0);
      chk("b_word3", int'(b_words[3]), 2);
    end

    // Ramp frame on the default instance.
    run_a_frame(t0);
    chk("ramp_rd_first", a_rd_first, t0 + 1);
    chk("ramp_addr_cnt", a_addrs.size(), 72);
    bad = 0;
    foreach (a_addrs[i]) if (a_addrs[i] !== 9'(71 - i)) bad++;
    chk("ramp_addr_order", bad, 0);
    chk("ramp_first_rise", a_first_rise, t0 + 5);
    chk("ramp_edges", a_edges, 1152);
    chk("ramp_word_cnt", a_words.size(), 72);
    if (a_words.size() == 72) begin
      chk("ramp_word0", int'(a_words[0]), 'h4700);
      chk("ramp_word1", int'(a_words[1]), 'h4600);
      chk("ramp_word71", int'(a_words[71]), 0);
    end
    chk("ramp_le_first", a_le_first, t0 + 4753);
    chk("ramp_le_len", a_le_n, 4);
    chk("ramp_done_cyc", a_done_cyc, t0 + 4757);
    chk("ramp_done_cnt", a_done_n, 1);
    chk("ramp_busy_first", a_busy_first, t0 + 1);
    chk("ramp_busy_last", a_busy_last, t0 + 4756);
    chk("ramp_busy_len", a_busy_n, 4756);
    chk("ramp_dclk_in_fetch", a_dclk_bad, 0);

    // Constant 0xA5 frame with start pulses while busy (both must be ignored).
    mode_a5 = 1'b1;
    clr = 1'b1; step(1); clr = 1'b0;
    t0 = cyc; start_a = 1'b1; step(1); start_a = 1'b0;
    while (cyc < t0 + 100) step(1);
    start_a = 1'b1; step(1); start_a = 1'b0;
    while (cyc < t0 + 4756) step(1);
    start_a = 1'b1; step(1); start_a = 1'b0;
    step(20);
    chk("a5_done_cnt", a_done_n, 1);
    chk("a5_done_cyc", a_done_cyc, t0 + 4757);
    chk("a5_busy_len", a_busy_n, 4756);
    chk("a5_word_cnt", a_words.size(), 72);
    bad = 0;
    foreach (a_words[i]) if (a_words[i] !== 16'hA500) bad++;
    chk("a5_word_bad", bad, 0);
    chk("a5_dclk_in_fetch", a_dclk_bad, 0);
    mode_a5 = 1'b0;

    // Reset in the middle of shifting; outputs must clear without a clock edge.
    clr = 1'b1; step(1); clr = 1'b0;
    t0 = cyc; start_a = 1'b1; step(1); start_a = 1'b0;
    while (cyc < t0 + 2000) step(1);
    chk("pre_reset_busy", int'(a_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", int'({a_rd_en, a_rd_addr, a_dclk, a_sdi, a_le, a_busy, a_done}), 0);
    step(3);
    rst_n = 1'b1;
    step(2);
    chk("abort_no_le", a_le_n, 0);
    chk("abort_idle_busy", int'(a_busy), 0);
    run_a_frame(t1);
    chk("restart_rd_first", a_rd_first, t1 + 1);
    chk("restart_addr0", (a_addrs.size() > 0) ? int'(a_addrs[0]) : -1, 71);
    chk("restart_edges", a_edges, 1152);
    chk("restart_word0", (a_words.size() > 0) ? int'(a_words[0]) : -1, 'h4700);
    chk("restart_le_first", a_le_first, t1 + 4753);
    chk("restart_done_cyc", a_done_cyc, t1 + 4757);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
